mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF-stage fetch port and the MEM-stage load/store port of the five-stage pipeline.
- Sequences each memory access and returns the read data to the port that asked for it.
- Drives stall signals to the PC/IF_ID hold logic and to the whole pipeline.
- Data accesses take priority over fetches because they belong to the older instruction.

Parameters:
- MEM_LATENCY, 2: cycles the memory needs from a stable request to valid mem_rdata; legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address (the PC).
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for a fetch.
- dm_read  in  1  load request; held until dm_ready.
- dm_write  in  1  store request; held until dm_ready.
- dm_addr  in  ADDR_W  load/store address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for a load or store.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  holds PC and IF_ID.
- stall_pipe  out  1  holds all pipeline registers.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; counter=0; mem_en=0, mem_we=0; mem_addr, mem_wdata, if_rdata, dm_rdata all 0; if_ready=0, dm_ready=0.
- Reset asserted mid-access aborts the access immediately. No ready pulse is produced for it, and the requester must re-request after reset.
- States: IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I.
- IDLE with dm_read|dm_write=1: latch dm_addr and dm_wdata into mem_addr/mem_wdata; mem_we=dm_write; mem_en=1; counter=0; go to BUSY_D.
- IDLE with only if_req=1: latch if_addr; mem_we=0; mem_en=1; counter=0; go to BUSY_I.
- IDLE with data and fetch requests in the same cycle: data wins. The fetch is serviced in the next IDLE cycle that has no data request.
- dm_read and dm_write both at 1 is illegal. It is treated as a write.
- BUSY_x: mem_en, mem_we, mem_addr and mem_wdata are held stable. Counter increments each cycle. When counter==MEM_LATENCY-1: capture mem_rdata into dm_rdata or if_rdata (store: dm_rdata unchanged), drop mem_en to 0, go to RESP_x.
- RESP_x: the matching ready output is 1 for exactly this cycle. Next state is IDLE. Requests seen during RESP are ignored.
- Latency: request present in IDLE at edge N gives ready high in cycle N+MEM_LATENCY+1. Back-to-back accesses cost MEM_LATENCY+2 cycles each.
- if_rdata/dm_rdata keep their last captured value until the next capture.
- stall_if = if_req & ~if_ready, combinational.
- stall_pipe = (dm_read|dm_write) & ~dm_ready, combinational.
- No fairness counter: continuous data requests starve fetch by design. The pipeline cannot issue back-to-back memory operations without a fetch in between.
- Addresses are forwarded unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro: MEM_ARB_FETCH_HIT_EN.
- When defined, a one-entry fetch buffer holds {valid, addr[ADDR_W-1:2], data}. It is loaded at every BUSY_I capture.
- In IDLE with if_req=1, no data request, valid=1 and if_addr[ADDR_W-1:2] matching the stored address: load if_rdata from the buffer and go straight to RESP_I, with no memory access (mem_en stays 0). Ready arrives 1 cycle after the request.
- A data write whose address[ADDR_W-1:2] matches the stored address clears valid at its BUSY_D entry.
- Reset clears valid.
- When the macro is not defined, there is no buffer and every fetch goes to memory.

Test Plan:
- MEM_LATENCY=2, if_req=1, if_addr=0x00000004, memory returns 0x8C010000 -> mem_en high 2 cycles with mem_addr=0x4, mem_we=0; if_ready pulses 3 cycles after request with if_rdata=0x8C010000; stall_if high until that pulse.
- dm_read and if_req together (dm_addr=0x10, data 0x0000002A; if_addr=0x8) -> load serviced first, dm_ready with dm_rdata=0x2A; fetch of 0x8 starts in the next IDLE; no memory cycles overlap.
- dm_write, dm_addr=0x20, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF held for 2 cycles; dm_ready pulses once; dm_rdata unchanged.
- reset driven 0 during the 2nd BUSY_D cycle -> all outputs 0 immediately; no dm_ready; after reset=1 with the request still held, the access restarts from IDLE.
- Sweep MEM_LATENCY=1 and 15 -> ready arrives exactly MEM_LATENCY+1 cycles after acceptance; holding the request through RESP does not start a duplicate access in the RESP cycle.
- MEM_ARB_FETCH_HIT_EN: fetch 0x40 twice -> second fetch gets if_ready 1 cycle after request with mem_en=0; store to 0x40 then fetch 0x40 -> full memory access occurs.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, the load/store port, the unified memory bus and the
// two pipeline stall lines shared by the arbiter and its surroundings.
// slave  : the arbiter's view (takes requests, drives memory and stalls).
// master : the pipeline/memory view (drives requests and read data).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_pipe;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_pipe
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_pipe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the IF fetch port and
// the MEM load/store port. Data accesses win over fetches (older instruction).
// Each access: accept in IDLE, hold the bus for MEM_LATENCY cycles, capture,
// then one RESP cycle carrying the ready pulse.
// Optional build macro MEM_ARB_FETCH_HIT_EN adds a one-entry fetch buffer that
// answers a repeated fetch of the same word without touching memory.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_D = 3'd1,
        ST_BUSY_I = 3'd2,
        ST_RESP_D = 3'd3,
        ST_RESP_I = 3'd4
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(MEM_LATENCY - 1);

    state_t            state_r;
    logic [3:0]        count_r;
    logic              dm_req_s;
    logic              capture_s;
    logic              fetch_hit_s;
    logic [DATA_W-1:0] hit_data_s;

    assign dm_req_s  = bus.dm_read | bus.dm_write;
    assign capture_s = (count_r == LAST_COUNT);

    // Stalls follow the raw request until its ready pulse arrives.
    assign bus.stall_if   = bus.if_req & ~bus.if_ready;
    assign bus.stall_pipe = dm_req_s & ~bus.dm_ready;

`ifdef MEM_ARB_FETCH_HIT_EN
    logic              buf_valid_r;
    logic [ADDR_W-3:0] buf_tag_r;
    logic [DATA_W-1:0] buf_data_r;

    assign fetch_hit_s = buf_valid_r & (bus.if_addr[ADDR_W-1:2] == buf_tag_r);
    assign hit_data_s  = buf_data_r;

    // Fetch buffer: refilled on every fetch capture, dropped by a store to its word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= {(ADDR_W-2){1'b0}};
            buf_data_r  <= {DATA_W{1'b0}};
        end else if ((state_r == ST_IDLE) && bus.dm_write &&
                     (bus.dm_addr[ADDR_W-1:2] == buf_tag_r)) begin
            buf_valid_r <= 1'b0;
        end else if ((state_r == ST_BUSY_I) && capture_s) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= bus.mem_addr[ADDR_W-1:2];
            buf_data_r  <= bus.mem_rdata;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end
`else
    assign fetch_hit_s = 1'b0;
    assign hit_data_s  = {DATA_W{1'b0}};
`endif

    // Access sequencer: arbitration, bus hold, read-data capture and ready pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            count_r       <= 4'd0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.if_rdata  <= {DATA_W{1'b0}};
            bus.dm_rdata  <= {DATA_W{1'b0}};
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dm_req_s) begin
                        // read+write together is treated as a write
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        bus.mem_we    <= bus.dm_write;
                        bus.mem_en    <= 1'b1;
                        count_r       <= 4'd0;
                        state_r       <= ST_BUSY_D;
                    end else if (bus.if_req && fetch_hit_s) begin
                        bus.if_rdata  <= hit_data_s;
                        bus.if_ready  <= 1'b1;
                        state_r       <= ST_RESP_I;
                    end else if (bus.if_req) begin
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_we    <= 1'b0;
                        bus.mem_en    <= 1'b1;
                        count_r       <= 4'd0;
                        state_r       <= ST_BUSY_I;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (capture_s) begin
                        if (!bus.mem_we) begin
                            bus.dm_rdata <= bus.mem_rdata;
                        end else begin
                            bus.dm_rdata <= bus.dm_rdata;
                        end
                        bus.mem_en   <= 1'b0;
                        bus.dm_ready <= 1'b1;
                        state_r      <= ST_RESP_D;
                    end else begin
                        count_r      <= count_r + 4'd1;
                    end
                end
                ST_BUSY_I: begin
                    if (capture_s) begin
                        bus.if_rdata <= bus.mem_rdata;
                        bus.mem_en   <= 1'b0;
                        bus.if_ready <= 1'b1;
                        state_r      <= ST_RESP_I;
                    end else begin
                        count_r      <= count_r + 4'd1;
                    end
                end
                ST_RESP_D: begin
                    bus.dm_ready <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                ST_RESP_I: begin
                    bus.if_ready <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    bus.mem_en   <= 1'b0;
                    bus.if_ready <= 1'b0;
                    bus.dm_ready <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Three arbiters (MEM_LATENCY 2, 1, 15) run side by side. A transaction-level
// model predicts every output each cycle; directed sequences pin the model with
// literal expectations, then random request traffic runs against it.
module tb_mem_port_arbiter;
    localparam int NI = 3;
    localparam int LATS [NI] = '{2, 1, 15};
`ifdef MEM_ARB_FETCH_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        if_req   [NI];
    logic [31:0] if_addr  [NI];
    logic        dm_read  [NI];
    logic        dm_write [NI];
    logic [31:0] dm_addr  [NI];
    logic [31:0] dm_wdata [NI];
    logic [31:0] mem_rdata[NI];

    logic        d_if_ready[NI], d_dm_ready[NI], d_mem_en[NI], d_mem_we[NI];
    logic        d_stall_if[NI], d_stall_pipe[NI];
    logic [31:0] d_if_rdata[NI], d_dm_rdata[NI], d_mem_addr[NI], d_mem_wdata[NI];
    int          en_cnt[NI];

    // model state: one in-flight transaction per instance
    logic        m_en[NI], m_we[NI], m_if_ready[NI], m_dm_ready[NI], m_resp[NI], m_bv[NI];
    logic [31:0] m_addr[NI], m_wdata[NI], m_if_rdata[NI], m_dm_rdata[NI], m_bdata[NI];
    logic [29:0] m_btag[NI];
    int          m_wait[NI], m_kind[NI];

    int vectors;
    int errors;

    // memory contents (read-only)
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h8C01_0000;
        else if (a == 32'h0000_0010) return 32'h0000_002A;
        else return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
            assign bus.if_req    = if_req[g];
            assign bus.if_addr   = if_addr[g];
            assign bus.dm_read   = dm_read[g];
            assign bus.dm_write  = dm_write[g];
            assign bus.dm_addr   = dm_addr[g];
            assign bus.dm_wdata  = dm_wdata[g];
            assign bus.mem_rdata = mem_rdata[g];
            assign d_if_ready[g]   = bus.if_ready;
            assign d_dm_ready[g]   = bus.dm_ready;
            assign d_mem_en[g]     = bus.mem_en;
            assign d_mem_we[g]     = bus.mem_we;
            assign d_stall_if[g]   = bus.stall_if;
            assign d_stall_pipe[g] = bus.stall_pipe;
            assign d_if_rdata[g]   = bus.if_rdata;
            assign d_dm_rdata[g]   = bus.dm_rdata;
            assign d_mem_addr[g]   = bus.mem_addr;
            assign d_mem_wdata[g]  = bus.mem_wdata;
            // data only valid once the request has been stable long enough
            assign mem_rdata[g] = (d_mem_en[g] && (en_cnt[g] >= LATS[g] - 1)) ?
                                  memf(d_mem_addr[g]) : (32'hBAD0_0000 | 32'(en_cnt[g]));
            mem_port_arbiter #(.MEM_LATENCY(LATS[g]), .ADDR_W(32), .DATA_W(32)) dut (
                .clk(clk), .reset(reset), .bus(bus));
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory-side count of cycles the enable has been held
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (!reset) en_cnt[i] <= 0;
            else en_cnt[i] <= d_mem_en[i] ? en_cnt[i] + 1 : 0;
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input int i, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %b expected %b at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_en[i] = 1'b0; m_we[i] = 1'b0; m_if_ready[i] = 1'b0; m_dm_ready[i] = 1'b0;
        m_resp[i] = 1'b0; m_bv[i] = 1'b0; m_addr[i] = 32'd0; m_wdata[i] = 32'd0;
        m_if_rdata[i] = 32'd0; m_dm_rdata[i] = 32'd0; m_bdata[i] = 32'd0;
        m_btag[i] = 30'd0; m_wait[i] = 0; m_kind[i] = 0;
    endtask

    // predict the outputs after the coming edge from the current inputs
    task automatic advance(input int i);
        logic hit;
        m_if_ready[i] = 1'b0;
        m_dm_ready[i] = 1'b0;
        if (m_resp[i]) begin
            m_resp[i] = 1'b0;
        end else if (m_wait[i] > 0) begin
            m_wait[i]--;
            if (m_wait[i] == 0) begin
                m_en[i]   = 1'b0;
                m_resp[i] = 1'b1;
                if (m_kind[i] == 1) begin
                    m_if_rdata[i] = memf(m_addr[i]);
                    m_if_ready[i] = 1'b1;
                    m_bv[i] = 1'b1; m_btag[i] = m_addr[i][31:2]; m_bdata[i] = m_if_rdata[i];
                end else if (m_kind[i] == 2) begin
                    m_dm_rdata[i] = memf(m_addr[i]);
                    m_dm_ready[i] = 1'b1;
                end else begin
                    m_dm_ready[i] = 1'b1;
                end
            end
        end else if (dm_read[i] || dm_write[i]) begin
            m_en[i] = 1'b1; m_we[i] = dm_write[i]; m_addr[i] = dm_addr[i];
            m_wdata[i] = dm_wdata[i]; m_wait[i] = LATS[i];
            m_kind[i] = dm_write[i] ? 3 : 2;
            if (dm_write[i] && dm_addr[i][31:2] == m_btag[i]) m_bv[i] = 1'b0;
        end else if (if_req[i]) begin
            hit = HIT_EN && m_bv[i] && (if_addr[i][31:2] == m_btag[i]);
            if (hit) begin
                m_if_rdata[i] = m_bdata[i];
                m_if_ready[i] = 1'b1;
                m_resp[i] = 1'b1;
            end else begin
                m_en[i] = 1'b1; m_we[i] = 1'b0; m_addr[i] = if_addr[i];
                m_wait[i] = LATS[i]; m_kind[i] = 1;
            end
        end
    endtask

    task automatic compare(input int i);
        chk1("mem_en", i, d_mem_en[i], m_en[i]);
        if (m_en[i]) begin
            chk1("mem_we", i, d_mem_we[i], m_we[i]);
            chk("mem_addr", i, d_mem_addr[i], m_addr[i]);
            if (m_we[i]) chk("mem_wdata", i, d_mem_wdata[i], m_wdata[i]);
        end
        chk1("if_ready", i, d_if_ready[i], m_if_ready[i]);
        chk1("dm_ready", i, d_dm_ready[i], m_dm_ready[i]);
        chk("if_rdata", i, d_if_rdata[i], m_if_rdata[i]);
        chk("dm_rdata", i, d_dm_rdata[i], m_dm_rdata[i]);
        chk1("stall_if", i, d_stall_if[i], if_req[i] & ~m_if_ready[i]);
        chk1("stall_pipe", i, d_stall_pipe[i], (dm_read[i] | dm_write[i]) & ~m_dm_ready[i]);
    endtask

    // check at the falling edge, then move to just after the next rising edge
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!reset) model_reset(i);
            compare(i);
            if (reset) advance(i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k, input bit fetch, output int n, output bit saw_en);
        bit done;
        done = 1'b0; n = 0; saw_en = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            n++;
            if (d_mem_en[k]) saw_en = 1'b1;
            if (fetch ? d_if_ready[k] : d_dm_ready[k]) done = 1'b1;
        end
    endtask

    task automatic drive_random(input int i);
        int r;
        if ((dm_read[i] || dm_write[i]) && d_dm_ready[i]) begin
            dm_read[i] = 1'b0; dm_write[i] = 1'b0;
        end
        if (if_req[i] && d_if_ready[i]) if_req[i] = 1'b0;
        if (!(dm_read[i] || dm_write[i]) && $urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 9);
            dm_read[i]  = (r < 5) || (r == 9);
            dm_write[i] = (r >= 5);
            dm_addr[i]  = $urandom_range(0, 15) * 32'd4;
            dm_wdata[i] = $urandom;
        end
        if (!if_req[i] && $urandom_range(0, 1) == 0) begin
            if_req[i]  = 1'b1;
            if_addr[i] = $urandom_range(0, 15) * 32'd4;
        end
    endtask

    initial begin
        int  n;
        bit  saw;
        vectors = 0;
        errors  = 0;
        reset   = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 1'b0; if_addr[i] = 32'd0; dm_read[i] = 1'b0; dm_write[i] = 1'b0;
            dm_addr[i] = 32'd0; dm_wdata[i] = 32'd0;
            model_reset(i);
        end
        repeat (3) step();
        chk1("rst_mem_en", 0, d_mem_en[0], 1'b0);
        chk("rst_if_rdata", 0, d_if_rdata[0], 32'h0);
        reset = 1'b1;
        step();

        // fetch of 0x4 on the latency-2 instance
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0004;
        step();
        chk1("f_en1", 0, d_mem_en[0], 1'b1);
        chk("f_addr", 0, d_mem_addr[0], 32'h0000_0004);
        chk1("f_we", 0, d_mem_we[0], 1'b0);
        chk1("f_stall", 0, d_stall_if[0], 1'b1);
        step();
        chk1("f_en2", 0, d_mem_en[0], 1'b1);
        chk1("f_rdy_early", 0, d_if_ready[0], 1'b0);
        step();
        chk1("f_rdy", 0, d_if_ready[0], 1'b1);
        chk("f_data", 0, d_if_rdata[0], 32'h8C01_0000);
        chk1("f_en_off", 0, d_mem_en[0], 1'b0);
        chk1("f_stall_off", 0, d_stall_if[0], 1'b0);
        if_req[0] = 1'b0;
        step();
        chk1("f_pulse", 0, d_if_ready[0], 1'b0);

        // load and fetch together: load first, fetch in the following IDLE
        dm_read[0] = 1'b1; dm_addr[0] = 32'h0000_0010;
        if_req[0]  = 1'b1; if_addr[0] = 32'h0000_0008;
        step();
        chk("lf_addr", 0, d_mem_addr[0], 32'h0000_0010);
        chk1("lf_stall_pipe", 0, d_stall_pipe[0], 1'b1);
        step();
        step();
        chk1("lf_dm_rdy", 0, d_dm_ready[0], 1'b1);
        chk("lf_dm_data", 0, d_dm_rdata[0], 32'h0000_002A);
        chk1("lf_if_rdy", 0, d_if_ready[0], 1'b0);
        dm_read[0] = 1'b0;
        step();
        chk1("lf_idle_gap", 0, d_mem_en[0], 1'b0);
        step();
        chk1("lf_f_en", 0, d_mem_en[0], 1'b1);
        chk("lf_f_addr", 0, d_mem_addr[0], 32'h0000_0008);
        step();
        step();
        chk1("lf_f_rdy", 0, d_if_ready[0], 1'b1);
        if_req[0] = 1'b0;
        step();

        // store leaves dm_rdata untouched
        dm_write[0] = 1'b1; dm_addr[0] = 32'h0000_0020; dm_wdata[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            step();
            chk1("st_we", 0, d_mem_we[0], 1'b1);
            chk("st_wdata", 0, d_mem_wdata[0], 32'hDEAD_BEEF);
        end
        step();
        chk1("st_rdy", 0, d_dm_ready[0], 1'b1);
        chk("st_rdata_kept", 0, d_dm_rdata[0], 32'h0000_002A);
        dm_write[0] = 1'b0;
        step();

        // reset during the second BUSY_D cycle
        dm_read[0] = 1'b1; dm_addr[0] = 32'h0000_0030;
        step();
        step();
        reset = 1'b0;
        #1;
        chk1("ar_en", 0, d_mem_en[0], 1'b0);
        chk1("ar_we", 0, d_mem_we[0], 1'b0);
        chk("ar_addr", 0, d_mem_addr[0], 32'h0);
        chk("ar_rdata", 0, d_dm_rdata[0], 32'h0);
        chk1("ar_rdy", 0, d_dm_ready[0], 1'b0);
        step();
        reset = 1'b1;
        step();
        chk1("ar_restart", 0, d_mem_en[0], 1'b1);
        chk("ar_restart_addr", 0, d_mem_addr[0], 32'h0000_0030);
        step();
        step();
        chk1("ar_done", 0, d_dm_ready[0], 1'b1);
        dm_read[0] = 1'b0;
        step();

        // latency sweep; the request is still held through RESP
        for (int k = 1; k < NI; k++) begin
            dm_read[k] = 1'b1; dm_addr[k] = 32'h0000_0014;
            wait_ready(k, 1'b0, n, saw);
            chk("lat_cycles", k, 32'(n), 32'(LATS[k] + 1));
            step();
            chk1("resp_no_dup", k, d_mem_en[k], 1'b0);
            dm_read[k] = 1'b0;
            step();
        end

`ifdef MEM_ARB_FETCH_HIT_EN
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0040;
        wait_ready(0, 1'b1, n, saw);
        chk("hit_first", 0, 32'(n), 32'd3);
        if_req[0] = 1'b0;
        step();
        if_req[0] = 1'b1;
        wait_ready(0, 1'b1, n, saw);
        chk("hit_second", 0, 32'(n), 32'd1);
        chk1("hit_no_mem", 0, saw, 1'b0);
        chk("hit_data", 0, d_if_rdata[0], memf(32'h0000_0040));
        if_req[0] = 1'b0;
        step();
        dm_write[0] = 1'b1; dm_addr[0] = 32'h0000_0040; dm_wdata[0] = 32'h1234_5678;
        wait_ready(0, 1'b0, n, saw);
        dm_write[0] = 1'b0;
        step();
        if_req[0] = 1'b1;
        wait_ready(0, 1'b1, n, saw);
        chk("hit_inval", 0, 32'(n), 32'd3);
        chk1("hit_inval_mem", 0, saw, 1'b1);
        if_req[0] = 1'b0;
        step();
`endif

        // random traffic with occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            for (int i = 0; i < NI; i++) drive_random(i);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
